// File: rtl/meter_scheduler.sv
// Peak meter front end: per-window peak of the selected source, double-dabble BCD
// conversion with 9999 clamp, and manual/auto source alternation at window boundaries.
module meter_scheduler #(
  parameter int WINDOW       = 4800,
  parameter int AUTO_WINDOWS = 10
) (
  input  logic               clk_48,
  input  logic               reset_n,
  input  logic signed [15:0] inWave,
  input  logic signed [15:0] outWave,
  input  logic               sel_btn,
  input  logic               auto_mode,
  output logic               src_sel,
  output logic [3:0]         num3,
  output logic [3:0]         num2,
  output logic [3:0]         num1,
  output logic [3:0]         num0,
  output logic               peak_valid,
  output logic               busy
);

  localparam logic [15:0] WIN_LAST  = 16'(WINDOW - 1);
  localparam logic [7:0]  AUTO_LAST = 8'(AUTO_WINDOWS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, next_state;
  logic signed [15:0] sample;
  logic [15:0]        neg;
  logic [14:0]        mag, peak, peak_in;
  logic [15:0]        cnt;
  logic               win_end;
  logic               btn_q, mode_q, pending, rise, mode_chg;
  logic [7:0]         wcnt;
  logic [15:0]        bin;
  logic [19:0]        bcd;
  logic [15:0]        adj;
  logic [3:0]         bit_cnt;

  // Magnitude; only -32768 has bit 15 set after negation, so that bit flags saturation.
  assign sample  = src_sel ? outWave : inWave;
  assign neg     = 16'(-sample);
  assign mag     = sample[15] ? (neg[15] ? 15'h7fff : neg[14:0]) : sample[14:0];
  assign peak_in = (mag > peak) ? mag : peak;
  assign win_end = (cnt == WIN_LAST);

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      peak <= '0;
    end else begin
      cnt  <= win_end ? '0 : cnt + 16'd1;
      peak <= win_end ? '0 : peak_in;
    end
  end

  // Source selection
  assign rise     = sel_btn & ~btn_q;
  assign mode_chg = auto_mode ^ mode_q;

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      btn_q   <= 1'b0;
      mode_q  <= 1'b0;
      pending <= 1'b0;
      wcnt    <= '0;
      src_sel <= 1'b0;
    end else begin
      btn_q  <= sel_btn;
      mode_q <= auto_mode;
      if (auto_mode) begin
        pending <= 1'b0;
        if (mode_chg) begin
          wcnt <= '0;
        end else if (win_end) begin
          if (wcnt == AUTO_LAST) begin
            wcnt    <= '0;
            src_sel <= ~src_sel;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
      end else begin
        wcnt <= '0;
        if (win_end) begin
          // an edge landing on the boundary cycle counts for this boundary
          if (pending | rise) src_sel <= ~src_sel;
          pending <= 1'b0;
        end else if (rise) begin
          pending <= 1'b1;
        end
      end
    end
  end

  // Converter FSM
  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (win_end) next_state = SHIFT;
      SHIFT:   if (bit_cnt == 4'd15) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Ten-thousands digit never exceeds 3 for a 15-bit input, so it needs no add-3.
  always_comb begin
    for (int i = 0; i < 4; i++)
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      bin        <= '0;
      bcd        <= '0;
      bit_cnt    <= '0;
      num3       <= '0;
      num2       <= '0;
      num1       <= '0;
      num0       <= '0;
      peak_valid <= 1'b0;
    end else begin
      peak_valid <= (state == DONE);
      case (state)
        IDLE: if (win_end) begin
          bin     <= {1'b0, peak_in};
          bcd     <= '0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          {bcd, bin} <= {bcd[18:16], adj, bin, 1'b0};
          bit_cnt    <= bit_cnt + 4'd1;
        end
        DONE: begin
          if (bcd[19:16] != 4'd0) begin
            num3 <= 4'd9;
            num2 <= 4'd9;
            num1 <= 4'd9;
            num0 <= 4'd9;
          end else begin
            num3 <= bcd[15:12];
            num2 <= bcd[11:8];
            num1 <= bcd[7:4];
            num0 <= bcd[3:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_meter_scheduler.sv
// Randomized bench for meter_scheduler: window-level reference model predicts
// src_sel, busy, peak_valid and displayed digits every cycle.
module tb_meter_scheduler;
  localparam int WIN  = 48;
  localparam int AUTO = 2;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic signed [15:0] in_wave = '0, out_wave = '0;
  logic               btn = 1'b0, am = 1'b0;
  logic               src_sel, peak_valid, busy;
  logic [3:0]         num3, num2, num1, num0;

  meter_scheduler #(.WINDOW(WIN), .AUTO_WINDOWS(AUTO)) dut (
    .clk_48(clk), .reset_n(reset_n), .inWave(in_wave), .outWave(out_wave),
    .sel_btn(btn), .auto_mode(am), .src_sel(src_sel),
    .num3(num3), .num2(num2), .num1(num1), .num0(num0),
    .peak_valid(peak_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0, errs = 0;
  // reference model state, indexed by cycle since reset release
  int c, m_max, m_end, m_val, m_num, m_wcnt;
  bit m_src, m_pend, m_btn_prev, m_mode_prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, c);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic signed [15:0] gen(input int mode, input int amp, input int k);
    case (mode)
      0:       return 16'(amp);
      1:       return 16'(int'($urandom_range(0, 2 * amp)) - amp);
      default: return 16'($rtoi(amp * $sin(2.0 * 3.14159265358979 * k / 48.0)));
    endcase
  endfunction

  task automatic model_reset();
    c = 0; m_max = 0; m_end = -1000; m_val = 0; m_num = 0; m_wcnt = 0;
    m_src = 0; m_pend = 0; m_btn_prev = 0; m_mode_prev = 0;
  endtask

  task automatic step(input logic signed [15:0] iw, input logic signed [15:0] ow,
                      input logic b, input logic a);
    int  samp, mag;
    bit  rise, wend, nsrc;
    @(negedge clk);
    if (c == m_end + 18) m_num = m_val;
    chk("src",   32'(src_sel), 32'(m_src));
    chk("busy",  32'(busy), 32'(c > m_end && c <= m_end + 17));
    chk("valid", 32'(peak_valid), 32'(c == m_end + 18));
    chk("num",   32'({num3, num2, num1, num0}), 32'(to_bcd(m_num)));
    in_wave = iw; out_wave = ow; btn = b; am = a;
    samp = m_src ? int'(ow) : int'(iw);
    mag  = (samp < 0) ? -samp : samp;
    if (mag > 32767) mag = 32767;
    if (mag > m_max) m_max = mag;
    wend = (c % WIN == WIN - 1);
    if (wend) begin
      m_end = c;
      m_val = (m_max > 9999) ? 9999 : m_max;
      m_max = 0;
    end
    rise = b && !m_btn_prev;
    nsrc = m_src;
    if (!a) begin
      m_wcnt = 0;
      if (wend) begin
        if (m_pend || rise) nsrc = !m_src;
        m_pend = 0;
      end else if (rise) m_pend = 1;
    end else begin
      m_pend = 0;
      if (a != m_mode_prev) m_wcnt = 0;
      else if (wend) begin
        m_wcnt++;
        if (m_wcnt == AUTO) begin nsrc = !m_src; m_wcnt = 0; end
      end
    end
    m_btn_prev = b; m_mode_prev = a; m_src = nsrc;
    c++;
  endtask

  task automatic window(input int imode, input int iamp, input int omode, input int oamp,
                        input logic [47:0] bpat, input logic a);
    logic [47:0] p;
    p = bpat;
    for (int k = 0; k < WIN; k++) step(gen(imode, iamp, k), gen(omode, oamp, k), p[k], a);
  endtask

  task automatic rst_check(input string tag);
    chk(tag, 32'({src_sel, busy, peak_valid, num3, num2, num1, num0}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; btn = 1'b0; am = 1'b0;
    #1 rst_check("rst_now");
    repeat (2) @(negedge clk);
    rst_check("rst_hold");
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [47:0] rp;
    model_reset();
    #2 rst_check("rst_init");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;

    window(2, 32767, 1, 1000, 48'd0, 1'b0);     // sine full scale -> 9999
    window(0, -4277, 1, 30000, 48'd0, 1'b0);    // -> 4277
    window(0, -32768, 1, 100, 48'd0, 1'b0);     // saturate -> 9999
    window(0, 0, 1, 30000, 48'h400, 1'b0);      // zero, press at count 10
    window(1, 30000, 2, 16384, 48'd0, 1'b0);    // outWave measured -> 9999
    window(1, 30000, 2, 2138, 48'd0, 1'b0);     // -> 2138
    window(1, 5000, 1, 7000, 48'h8000_0000_0000, 1'b0); // edge on boundary cycle
    window(1, 5000, 1, 7000, 48'h8420, 1'b0);   // three edges -> one toggle

    for (int w = 0; w < 6; w++) begin
      rp = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      window(1, $urandom_range(0, 14000), 1, $urandom_range(0, 14000), rp, 1'b0);
    end
    for (int w = 0; w < 6; w++) begin
      rp = {$urandom, $urandom} & {$urandom, $urandom};
      window(1, $urandom_range(0, 14000), 1, $urandom_range(0, 14000), rp, 1'b1);
    end
    for (int w = 0; w < 2; w++)
      window(1, $urandom_range(0, 12000), 1, $urandom_range(0, 12000), 48'h10, 1'b0);

    // reset while the converter is shifting
    window(0, 1234, 0, 4321, 48'd0, 1'b0);
    for (int k = 0; k < 5; k++) step(16'sd0, 16'sd0, 1'b0, 1'b0);
    do_reset();
    window(0, -777, 0, 50, 48'd0, 1'b0);
    window(1, 9000, 1, 9000, 48'd0, 1'b0);
    for (int k = 0; k < 22; k++) step(16'sd0, 16'sd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
